// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame transmitter: accepts a parallel frame over valid/ready and
// shifts it out MSB-first inside a single nss-low window.
module spi_frame_tx #(
    parameter int FRAME_BITS = 96,
    parameter int CLK_DIV    = 1,
    parameter int CS_IDLE    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] frame_data,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  nss,
    output logic                  sck,
    output logic                  mosi,
    output logic                  busy,
    output logic                  done
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(CS_IDLE + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t                state, state_nx;
    logic [FRAME_BITS-1:0] shreg, shreg_nx;
    logic [BW-1:0]         bit_cnt, bit_cnt_nx;
    logic [DW-1:0]         div, div_nx;
    logic [GW-1:0]         gap, gap_nx;
    logic                  phase, phase_nx;
    logic                  div_end;

    assign div_end = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div     <= '0;
            gap     <= '0;
            phase   <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            div     <= div_nx;
            gap     <= gap_nx;
            phase   <= phase_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        bit_cnt_nx  = bit_cnt;
        div_nx      = div;
        gap_nx      = gap;
        phase_nx    = phase;
        frame_ready = (state == IDLE) && rst_n;
        nss         = 1'b1;
        sck         = 1'b0;
        mosi        = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (frame_valid && frame_ready) begin
                    state_nx   = SHIFT;
                    shreg_nx   = frame_data;
                    bit_cnt_nx = '0;
                    div_nx     = '0;
                    phase_nx   = 1'b0;
                end
            end
            SHIFT: begin
                nss  = 1'b0;
                sck  = phase;
                mosi = shreg[FRAME_BITS-1];
                if (div_end) begin
                    div_nx = '0;
                    if (!phase) begin
                        phase_nx = 1'b1;
                    end else begin
                        // Data advances on the falling edge; the last bit is kept for HOLD.
                        phase_nx = 1'b0;
                        if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                            state_nx = HOLD;
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                            shreg_nx   = {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_nx = div + 1'b1;
                end
            end
            HOLD: begin
                nss  = 1'b0;
                mosi = shreg[FRAME_BITS-1];
                if (div_end) begin
                    div_nx   = '0;
                    gap_nx   = '0;
                    state_nx = GAP;
                end else begin
                    div_nx = div + 1'b1;
                end
            end
            GAP: begin
                done = (gap == '0);
                if (gap == GW'(CS_IDLE - 1)) state_nx = IDLE;
                else                         gap_nx   = gap + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two instances (CLK_DIV=1 and CLK_DIV=3) observed by a
// wire-level monitor that decodes frames and timing, compared to spec-derived values.
module tb_spi_frame_tx;
    localparam int F = 96;
    localparam logic [F-1:0] PAT = 96'h123456789ABCDEF012345678;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [F-1:0] fd0 = '0, fd1 = '0;
    logic [1:0]   valid = '0;
    wire  [1:0]   ready, nss, sck, mosi, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_frame_tx dut0 (
        .clk(clk), .rst_n(rst_n), .frame_data(fd0), .frame_valid(valid[0]),
        .frame_ready(ready[0]), .nss(nss[0]), .sck(sck[0]), .mosi(mosi[0]),
        .busy(busy[0]), .done(done[0])
    );

    spi_frame_tx #(.FRAME_BITS(F), .CLK_DIV(3), .CS_IDLE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_data(fd1), .frame_valid(valid[1]),
        .frame_ready(ready[1]), .nss(nss[1]), .sck(sck[1]), .mosi(mosi[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Monitor state, one slot per instance.
    int           low_run[2], rises[2], lo_run[2], hi_run[2], gap_run[2], mage[2], last_rise[2];
    int           frames[2], dones[2], last_low[2], last_gap[2];
    int           hi_bad[2], lo_bad[2], mosi_bad[2], sck_bad[2], done_bad[2];
    int           low_hist[2][8];
    logic [F-1:0] rx[2];
    logic [F-1:0] hist[2][8];
    logic         p_nss[2], p_sck[2], p_mosi[2];
    int           smp = 0;

    function automatic int cdiv(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (mosi[k] == p_mosi[k]) mage[k]++;
            else                      mage[k] = 0;
            if (!nss[k]) begin
                if (p_nss[k]) begin
                    last_gap[k]  = gap_run[k];
                    low_run[k]   = 0;
                    rises[k]     = 0;
                    rx[k]        = '0;
                    lo_run[k]    = 0;
                    hi_run[k]    = 0;
                    last_rise[k] = -1;
                end
                low_run[k]++;
                if (sck[k] && !p_sck[k]) begin
                    rises[k]++;
                    rx[k] = {rx[k][F-2:0], mosi[k]};
                    if (lo_run[k] != cdiv(k)) lo_bad[k]++;
                    if (mage[k] < cdiv(k))    mosi_bad[k]++;
                    last_rise[k] = smp;
                    hi_run[k]    = 0;
                end
                if (!sck[k] && p_sck[k]) begin
                    if (hi_run[k] != cdiv(k)) hi_bad[k]++;
                    lo_run[k] = 0;
                end
                if (sck[k]) hi_run[k]++;
                else        lo_run[k]++;
                if (!p_nss[k] && mosi[k] != p_mosi[k]) begin
                    if (!(p_sck[k] && !sck[k])) mosi_bad[k]++;
                    if (last_rise[k] >= 0 && (smp - last_rise[k]) < cdiv(k)) mosi_bad[k]++;
                end
            end else begin
                if (!p_nss[k]) begin
                    last_low[k]           = low_run[k];
                    hist[k][frames[k]%8]  = rx[k];
                    low_hist[k][frames[k]%8] = low_run[k];
                    frames[k]++;
                    gap_run[k] = 0;
                end
                gap_run[k]++;
                if (sck[k]) sck_bad[k]++;
            end
            if (done[k]) begin
                dones[k]++;
                if (!(nss[k] && !p_nss[k])) done_bad[k]++;
            end
            p_nss[k]  = nss[k];
            p_sck[k]  = sck[k];
            p_mosi[k] = mosi[k];
        end
        smp++;
    end

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            low_run[k] = 0; rises[k] = 0; lo_run[k] = 0; hi_run[k] = 0; gap_run[k] = 100;
            mage[k] = 0; last_rise[k] = -1; frames[k] = 0; dones[k] = 0;
            last_low[k] = 0; last_gap[k] = 0; hi_bad[k] = 0; lo_bad[k] = 0;
            mosi_bad[k] = 0; sck_bad[k] = 0; done_bad[k] = 0; rx[k] = '0;
            p_nss[k] = nss[k]; p_sck[k] = sck[k]; p_mosi[k] = mosi[k];
        end
    endtask

    function automatic logic [F-1:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int k, input logic [F-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        if (k == 0) fd0 = d;
        else        fd1 = d;
        valid[k] = 1'b1;
        while (!ready[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL accept_timeout k=%0d got ready=%b want 1", k, ready[k]);
        end
        @(negedge clk);
    endtask

    task automatic wait_frames(input int k, input int target);
        int n;
        n = 0;
        while (frames[k] < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frames[k] < target) begin
            errors++;
            $display("FAIL frame_timeout k=%0d got frames=%0d want %0d", k, frames[k], target);
        end
    endtask

    task automatic wait_rises(input int k, input int target);
        int n;
        n = 0;
        while (rises[k] < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rises[k] < target) begin
            errors++;
            $display("FAIL rise_timeout k=%0d got rises=%0d want %0d", k, rises[k], target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({nss[k], sck[k], mosi[k], busy[k], done[k], ready[k]} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got nss/sck/mosi/busy/done/ready=%b want 100000", k,
                         {nss[k], sck[k], mosi[k], busy[k], done[k], ready[k]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        checks++;
        if (ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 11", ready);
        end
    endtask

    task automatic test_single();
        int f0, d0;
        f0 = frames[0]; d0 = dones[0];
        send(0, PAT);
        valid[0] = 1'b0;
        wait_frames(0, f0 + 1);
        @(negedge clk);
        checks++;
        if (last_low[0] != (2 * F + 1) * 1) begin
            errors++; $display("FAIL single_nss_low got %0d want %0d", last_low[0], 2 * F + 1);
        end
        checks++;
        if (hist[0][f0%8] !== PAT) begin
            errors++; $display("FAIL single_data got %h want %h", hist[0][f0%8], PAT);
        end
        checks++;
        if (dones[0] - d0 != 1) begin
            errors++; $display("FAIL single_done_count got %0d want 1", dones[0] - d0);
        end
        checks++;
        if (rises[0] != F) begin
            errors++; $display("FAIL single_rises got %0d want %0d", rises[0], F);
        end
    endtask

    task automatic test_clkdiv3();
        int f0;
        logic [F-1:0] d;
        d = {12{8'hA5}};
        f0 = frames[1];
        send(1, d);
        valid[1] = 1'b0;
        wait_frames(1, f0 + 1);
        @(negedge clk);
        checks++;
        if (last_low[1] != (2 * F + 1) * 3) begin
            errors++; $display("FAIL div3_nss_low got %0d want %0d", last_low[1], (2 * F + 1) * 3);
        end
        checks++;
        if (hist[1][f0%8] !== d) begin
            errors++; $display("FAIL div3_data got %h want %h", hist[1][f0%8], d);
        end
        checks++;
        if (rises[1] != F) begin
            errors++; $display("FAIL div3_rises got %0d want %0d", rises[1], F);
        end
        checks++;
        if (hi_bad[1] != 0 || lo_bad[1] != 0) begin
            errors++; $display("FAIL div3_duty got hi_bad=%0d lo_bad=%0d want 0/0", hi_bad[1], lo_bad[1]);
        end
        checks++;
        if (mosi_bad[1] != 0) begin
            errors++; $display("FAIL div3_mosi_stable got %0d violations want 0", mosi_bad[1]);
        end
    endtask

    task automatic test_back_to_back();
        int f0, d0;
        logic [F-1:0] a, b;
        a = 96'h1;
        b = ~96'h1;
        f0 = frames[0]; d0 = dones[0];
        send(0, a);
        send(0, b);
        valid[0] = 1'b0;
        wait_frames(0, f0 + 2);
        @(negedge clk);
        checks++;
        if (last_gap[0] != 3) begin
            errors++; $display("FAIL b2b_nss_high got %0d want 3", last_gap[0]);
        end
        checks++;
        if (hist[0][f0%8] !== a) begin
            errors++; $display("FAIL b2b_first_data got %h want %h", hist[0][f0%8], a);
        end
        checks++;
        if (hist[0][(f0+1)%8] !== b) begin
            errors++; $display("FAIL b2b_second_data got %h want %h", hist[0][(f0+1)%8], b);
        end
        checks++;
        if (dones[0] - d0 != 2) begin
            errors++; $display("FAIL b2b_done_count got %0d want 2", dones[0] - d0);
        end
    endtask

    task automatic test_busy_ignore();
        int f0, d0;
        logic [F-1:0] d;
        d = rnd96();
        f0 = frames[0]; d0 = dones[0];
        send(0, d);
        valid[0] = 1'b0;
        wait_rises(0, 10);
        fd0 = {6{16'hDEAD}};
        valid[0] = 1'b1;
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++; $display("FAIL busy_ready got %b want 0", ready[0]);
        end
        @(negedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        wait_frames(0, f0 + 1);
        repeat (250) @(negedge clk);
        checks++;
        if (hist[0][f0%8] !== d) begin
            errors++; $display("FAIL busy_data got %h want %h", hist[0][f0%8], d);
        end
        checks++;
        if (frames[0] != f0 + 1 || dones[0] - d0 != 1) begin
            errors++; $display("FAIL busy_extra_frame got frames=%0d dones=%0d want 1/1",
                               frames[0] - f0, dones[0] - d0);
        end
    endtask

    task automatic test_reset_mid();
        int f0, d0;
        send(0, rnd96());
        valid[0] = 1'b0;
        wait_rises(0, 40);
        d0 = dones[0];
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({nss[0], sck[0], mosi[0], done[0]} !== 4'b1000) begin
            errors++; $display("FAIL midreset_outputs got nss/sck/mosi/done=%b want 1000",
                               {nss[0], sck[0], mosi[0], done[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (dones[0] != d0) begin
            errors++; $display("FAIL midreset_done got %0d pulses want 0", dones[0] - d0);
        end
        f0 = frames[0];
        send(0, PAT);
        valid[0] = 1'b0;
        wait_frames(0, f0 + 1);
        @(negedge clk);
        checks++;
        if (hist[0][f0%8] !== PAT || low_hist[0][f0%8] != 2 * F + 1) begin
            errors++; $display("FAIL midreset_next_frame got %h len=%0d want %h len=%0d",
                               hist[0][f0%8], low_hist[0][f0%8], PAT, 2 * F + 1);
        end
    endtask

    task automatic test_random();
        logic [F-1:0] d;
        int f0, k;
        for (int i = 0; i < 5; i++) begin
            k = (i == 4) ? 1 : 0;
            d = rnd96();
            f0 = frames[k];
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send(k, d);
            valid[k] = 1'b0;
            wait_frames(k, f0 + 1);
            @(negedge clk);
            checks++;
            if (hist[k][f0%8] !== d || low_hist[k][f0%8] != (2 * F + 1) * cdiv(k)) begin
                errors++; $display("FAIL random_frame%0d k=%0d got %h len=%0d want %h len=%0d", i, k,
                                   hist[k][f0%8], low_hist[k][f0%8], d, (2 * F + 1) * cdiv(k));
            end
        end
    endtask

    task automatic test_invariants();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (sck_bad[k] != 0 || done_bad[k] != 0) begin
                errors++; $display("FAIL invariants k=%0d got sck_idle_bad=%0d done_bad=%0d want 0/0",
                                   k, sck_bad[k], done_bad[k]);
            end
            checks++;
            if (hi_bad[k] != 0 || lo_bad[k] != 0 || mosi_bad[k] != 0) begin
                errors++; $display("FAIL timing k=%0d got hi=%0d lo=%0d mosi=%0d want 0", k,
                                   hi_bad[k], lo_bad[k], mosi_bad[k]);
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_clkdiv3();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- SPI initiator (transmit side) for the synth's configuration link.
- Takes a parallel configuration frame through a valid/ready handshake and serializes it MSB-first on nss/sck/mosi. Framing is one frame per nss-low window, which is what the spi receiver block expects.
- Used on-chip for self-test loopback and in the FPGA test harness that drives the receiver.

Parameters:
- FRAME_BITS, 96: frame length in bits. Must be ≥2.
- CLK_DIV, 1: sck half-period in clk cycles. Must be ≥1.
- CS_IDLE, 2: minimum clk cycles nss stays high between frames. Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- frame_data  in  FRAME_BITS  frame to send. Bit FRAME_BITS-1 is sent first.
- frame_valid  in  1  frame_data is valid.
- frame_ready  out  1  block can accept a frame this cycle.
- nss  out  1  chip select, active low.
- sck  out  1  serial clock. Idles low (mode 0).
- mosi  out  1  serial data.
- busy  out  1  high from acceptance until the block returns to IDLE.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: while rst_n=0 at a clk edge, next state is IDLE with nss=1, sck=0, mosi=0, busy=0, done=0, frame_ready=0. In IDLE with rst_n=1, frame_ready=1.
- States: IDLE → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - Accept a frame on frame_valid && frame_ready at edge T.
  - At T: shift register ← frame_data, bit counter ← 0, divider ← 0.
  - From cycle T+1: nss=0, busy=1, frame_ready=0, mosi=frame_data[FRAME_BITS-1].
- SHIFT: each bit i (0..FRAME_BITS-1) occupies 2*CLK_DIV cycles starting at T+1+2*i*CLK_DIV.
  - First CLK_DIV cycles: sck=0.
  - Next CLK_DIV cycles: sck=1.
  - mosi changes only in the cycle sck goes 1→0, or at frame start. It is stable for the whole bit.
  - The receiver samples on sck rising.
  - After the high phase of the last bit: sck=0 and go to HOLD.
- HOLD: nss stays 0 and mosi holds the last bit for CLK_DIV cycles.
  - Total nss-low time is exactly (2*FRAME_BITS+1)*CLK_DIV cycles.
- GAP: first GAP cycle has nss=1, mosi=0, done=1 (single cycle).
  - GAP lasts CS_IDLE cycles, then IDLE with frame_ready=1 and busy=0.
- Exactly FRAME_BITS sck rising edges per frame. sck never toggles while nss=1.
- frame_valid while frame_ready=0 is ignored. frame_data is don't-care after acceptance.
- Counters:
  - Bit counter is $clog2(FRAME_BITS+1) bits.
  - Divider is $clog2(CLK_DIV+1) bits.
  - No wrap occurs inside a frame.
- Reset mid-frame: the next edge forces nss=1, sck=0, mosi=0. No done pulse. The partial frame is dropped (the receiver sees nss rise). The next accepted frame is sent in full.
- Back-to-back: with frame_valid held high, the next frame is accepted in the first IDLE cycle. nss is high for exactly CS_IDLE+1 cycles between frames.

Test Plan:
- Reset: hold rst_n=0 for 3 clk → nss=1, sck=0, mosi=0, busy=0, done=0, frame_ready=0. Release → frame_ready=1 next cycle.
- Single frame, defaults: send 96'h123456789ABCDEF012345678 → nss low 193 cycles and exactly 96 sck rises. mosi sampled at the rises reassembles to 96'h123456789ABCDEF012345678. One done pulse in the cycle nss rises.
- CLK_DIV=3, frame 96'hA5…A5 → sck period 6 cycles, duty 3/3. mosi is stable ≥3 cycles before and ≥2 after every rise. nss low 579 cycles.
- Back-to-back: frames 96'h0…01 then 96'hF…FE with frame_valid held → second accepted the first IDLE cycle. nss high exactly 3 cycles between frames. Both frames decode correctly.
- Busy ignore: pulse frame_valid with 96'hDEAD… at bit 10 of a frame → no acceptance. The in-flight frame is unchanged and only one done pulse occurs.
- Reset mid-frame: assert rst_n=0 after 40 sck rises → nss=1, sck=0 next edge, no done. A subsequent 96'h123456789ABCDEF012345678 frame decodes correctly.
